// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Upstream/downstream handshake bundle for one pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  // Pipeline control side: produces beats, consumes them, raises flush.
  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  // The stage register itself.
  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register with flush, bubble-clean
//               control bus and optional 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 16,
  parameter int SKID      = 1,
  parameter int ZERO_DATA = 1
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  logic accept;
  logic pop;

  generate
    if (SKID != 0) begin : g_skid
      // Ready comes straight from state so out_ready never reaches in_ready.
      assign bus.in_ready = (state_q != ST_TWO);
    end else begin : g_no_skid
      assign bus.in_ready = (state_q == ST_EMPTY) | bus.out_ready;
    end
  endgenerate

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = (state_q != ST_EMPTY) & bus.out_ready;

  // Ctrl registers are zeroed whenever an entry empties, so the head is a
  // clean bubble without any output gating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (bus.flush) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      if (ZERO_DATA != 0) begin
        main_data_q <= '0;
        skid_data_q <= '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_data_q <= bus.in_data;
            main_ctrl_q <= bus.in_ctrl;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (pop && accept) begin
            main_data_q <= bus.in_data;
            main_ctrl_q <= bus.in_ctrl;
          end else if (pop) begin
            main_ctrl_q <= '0;
            if (ZERO_DATA != 0) main_data_q <= '0;
            state_q <= ST_EMPTY;
          end else if (accept && (SKID != 0)) begin
            skid_data_q <= bus.in_data;
            skid_ctrl_q <= bus.in_ctrl;
            state_q     <= ST_TWO;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            skid_ctrl_q <= '0;
            if (ZERO_DATA != 0) skid_data_q <= '0;
            state_q <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          main_ctrl_q <= '0;
          skid_ctrl_q <= '0;
        end
      endcase
    end
  end

  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.occupancy = state_q;

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the five-stage core.
- Generalises the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block. It carries an opaque data bus and a control bus, and adds a valid/ready handshake for stalls, synchronous flush and an optional 2-entry skid buffer.
- Control bits are forced to zero whenever the stage holds a bubble, so downstream stages never see stray reg_write or mem_write.

Parameters:
DATA_W, 32, width of datapath payload (pc, operands, imm, rd, funct3, ...)
CTRL_W, 16, width of control payload (alu_op, mem_read/write, reg_write, branch, jal, jalr, ...)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
ZERO_DATA, 1, 1 = data bits also cleared on reset/flush/pop-to-empty; 0 = data retained (ctrl always cleared)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held entries (branch mispredict / jump redirect)
in_valid  input  1  upstream has a beat
in_ready  output  1  stage can accept a beat this cycle
in_data  input  DATA_W  upstream data payload
in_ctrl  input  CTRL_W  upstream control payload
out_valid  output  1  stage presents a beat
out_ready  input  1  downstream accepts (deasserted = stall)
out_data  output  DATA_W  head data
out_ctrl  output  CTRL_W  head control; all-zero whenever out_valid=0
occupancy  output  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Both entries invalid; out_valid=0, out_ctrl=0, occupancy=0.
  - out_data=0 if ZERO_DATA=1.
  - in_ready=1 after reset.
  - Reset mid-transfer drops all held beats.
- Handshakes:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_data/in_ctrl are sampled only on accept.
- Latency: an accepted beat appears on out_* the next cycle when the stage was empty or popping; min latency 1, throughput 1 beat/cycle.
- SKID=1 states: EMPTY, ONE (main valid), TWO (main+skid valid). in_ready = ~skid_valid (a register, no combinational path from out_ready).
  - EMPTY: accept -> main<=in, ONE; else stay.
  - ONE: pop&accept -> main<=in, ONE; pop only -> clear main, EMPTY; accept only -> skid<=in, TWO; neither -> hold.
  - TWO (in_ready=0): pop -> main<=skid, clear skid, ONE; else hold.
- SKID=0: single main entry.
  - in_ready = ~main_valid | out_ready (combinational).
  - Transitions as EMPTY/ONE above; the accept-only-while-ONE case cannot occur.
- Flush (synchronous, priority over all but reset):
  - Next state EMPTY; ctrl (and data if ZERO_DATA) of both entries cleared.
  - An accept in the flush cycle is discarded.
  - A pop in the flush cycle counts as delivered.
- Bubble invariant: out_ctrl==0 whenever out_valid==0, including after pop-to-empty and after flush.
- Ordering: strict FIFO; no beat duplicated or lost except by flush/reset.
- in_valid with in_ready=0: inputs ignored; upstream holds its beat (no requirement on upstream stability is checked here).
- occupancy: EMPTY=0, ONE=1, TWO=2.

Test Plan:
- Streaming: SKID=1, out_ready=1, beats data 0x100,0x104,0x108 with ctrl 0x0011 on consecutive cycles -> outputs appear 1 cycle later, same order, one per cycle, occupancy stays 1, in_ready stays 1.
- Stall fills skid: out_ready=0, send 0xA0 then 0xA4 -> occupancy 2, in_ready=0, out_data=0xA0 held. Raise out_ready -> 0xA0 then 0xA4 popped, in_ready back to 1 one cycle after first pop.
- Flush: occupancy 2 (0xB0, 0xB4), assert flush with in_valid=1 data 0xB8 -> next cycle out_valid=0, out_ctrl=0x0000, occupancy=0, 0xB8 never emitted.
- Bubble invariant: single beat ctrl 0xFFFF popped with no follow-up -> next cycle out_valid=0 and out_ctrl=0x0000 (and out_data=0 with ZERO_DATA=1).
- SKID=0 pass-through stall: main holds 0xC0, out_ready=0 -> in_ready=0 same cycle. Set out_ready=1 with in_valid=1 data 0xC4 -> in_ready=1 combinationally, 0xC0 popped and 0xC4 loaded same edge.
- Async reset mid-operation: occupancy 2, drop reset_n between clock edges -> out_valid=0, out_ctrl=0, occupancy=0 immediately, without a clock edge. After release, first accepted beat 0xD0 appears after 1 cycle.
